data_mem: RTL and testbench
===========================

// Module: data_mem
// PURPOSE
//  Synthesizable data-memory responder for the CPU's byte-lane data port (mem_addr/mem_r/mem_w/mem_din/mem_dout).
//  It replaces the behavioural bench memory. RAM is byte-interleaved across XLEN/8 banks.
//  A small MMIO window provides HALT (end-of-program detect), CYCLE and FAULT_CNT registers.
//  Sits directly on the CPU data port; the instruction ROM is separate.
// PARAMETERS
//  XLEN         32            data/address width; BYTES = XLEN/8 lanes
//  DEPTH_WORDS  1024          RAM depth in XLEN-wide words; RAM spans [0, DEPTH_WORDS*BYTES)
//  MMIO_BASE    'hFFFF_FF00   base of MMIO window, XLEN bits, BYTES-aligned
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rstn       in   1        asynchronous reset, active low
//  mem_addr   in   XLEN     byte address of lane 0
//  mem_r      in   XLEN/8   read lane enables; lane i = byte mem_addr+i
//  mem_w      in   XLEN/8   write lane enables
//  mem_din    in   XLEN     write data, lane i = mem_din[8i+:8]
//  mem_dout   out  XLEN     read data, combinational
//  halt       out  1        sticky; set by a write to HALT
//  halt_code  out  XLEN     value written to HALT
//  fault      out  1        one-cycle pulse, registered, one cycle after a faulting access
// BEHAVIOUR
//  - Reset (async, rstn=0): halt=0, halt_code=0, fault=0, CYCLE=0, FAULT_CNT=0. RAM contents are NOT reset.
//  - Reads: combinational, zero latency. For lane i with mem_r[i]=1, mem_dout[8i+:8] = byte at mem_addr+i.
//    Lanes with mem_r[i]=0 read 0. Faulting lanes read 0.
//  - Writes: lane i with mem_w[i]=1 commits byte at rising clk. Same-cycle read returns the pre-write byte.
//  - Lane address = mem_addr+i, computed modulo 2^XLEN (wraps).
//    Bank = addr % BYTES; row = addr / BYTES.
//  - Access active when |mem_r or |mem_w. mem_r and mem_w both nonzero in one cycle is legal:
//    the read sees old data and the write commits.
//  - Fault conditions (per active access):
//    - any enabled lane outside both RAM and MMIO ranges;
//    - MMIO access that is not full-word (all lanes enabled, mem_addr BYTES-aligned);
//    - misaligned RAM access, subject to MISALIGN (see CONFIGURATION).
//    Faulting lanes are not written. fault pulses the next cycle. FAULT_CNT += 1, saturating at 255.
//  - MMIO map (offset from MMIO_BASE):
//    - +0 HALT: write sets halt=1 and halt_code=mem_din. Later writes update halt_code only. Reads return halt_code.
//    - +BYTES CYCLE: read-only. Increments every cycle while halt=0; freezes once halt=1. Wraps at 2^XLEN.
//      Writes are ignored, no fault.
//    - +2*BYTES FAULT_CNT: reads zero-extended. Any write clears it to 0.
//      If the clearing write's cycle also faults elsewhere, the clear wins.
//    - Other offsets in [MMIO_BASE, MMIO_BASE+4*BYTES) read 0, ignore writes, no fault.
//  - Reset asserted mid-access aborts the write (no partial commit guaranteed-free: lanes not yet clocked are lost).
// CONFIGURATION
//  - Macro DMEM_MISALIGN_EN:
//    - Defined: RAM accesses whose lanes cross a word boundary are served. The interleaved banks use row and row+1 per lane.
//    - Undefined: any RAM access with (mem_addr % BYTES) + highest enabled lane >= BYTES faults. No lane is written and all lanes read 0.
//  - MMIO alignment rules apply in both builds.
// STRUCTURE
//  - Package riscv_mem_pkg:
//    - typedef lane_mask_t;
//    - localparams MMIO_HALT_OFS, MMIO_CYCLE_OFS, MMIO_FCNT_OFS, MMIO_SPAN;
//    - FAULT_CNT_MAX = 255.
//  - Sub-module dmem_bank: one byte-wide DEPTH_WORDS-deep bank, async read / sync write. Instantiated BYTES times.
//  - Top holds lane-to-bank rotation, range decode, MMIO registers and fault logic.
// TESTING
//  1. sw 0xFC18 (-1000) @0, then lb/lbu/lh/lhu/lw @0.
//     -> dout lanes 0xFFFFFC18 as enabled; sb/sh/sw write-back to 4/12/20 match byte-exactly.
//  2. Write 0xAABBCCDD @8 (all lanes) while mem_r=0xF @8 in the same cycle.
//     -> dout = old value; next cycle dout = 0xAABBCCDD.
//  3. With DMEM_MISALIGN_EN: sh 0x1234 @3. -> byte3=0x34, byte4=0x12, no fault.
//     Without the macro: fault pulses 1 cycle later, bytes unchanged, FAULT_CNT=1.
//  4. lw @DEPTH_WORDS*BYTES. -> dout=0, fault pulse.
//     256 more such reads -> FAULT_CNT=255 (saturates). Write FAULT_CNT -> reads 0.
//  5. Run 10 cycles, then sw 7 to HALT.
//     -> halt=1, halt_code=7. CYCLE reads 10 and stays frozen.
//     Write 9 to HALT -> halt_code=9, halt stays 1.
//  6. Deassert rstn mid-run after halt.
//     -> halt/halt_code/CYCLE/FAULT_CNT/fault = 0 immediately; RAM byte @0 retained.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared types and constants for the data-memory responder.
package riscv_mem_pkg;

  // Widest lane mask supported (XLEN up to 64).
  localparam int unsigned MaxLanes = 8;
  typedef logic [MaxLanes-1:0] lane_mask_t;

  // MMIO register offsets from MMIO_BASE, in words (multiply by BYTES for bytes).
  localparam int unsigned MMIO_HALT_OFS  = 0;
  localparam int unsigned MMIO_CYCLE_OFS = 1;
  localparam int unsigned MMIO_FCNT_OFS  = 2;
  localparam int unsigned MMIO_SPAN      = 4;

  typedef logic [7:0] fault_cnt_t;
  localparam fault_cnt_t FAULT_CNT_MAX = 8'd255;

  // Index of the highest set lane in m, 0 when m is empty.
  function automatic int unsigned hi_lane(lane_mask_t m);
    int unsigned hi;
    hi = 0;
    for (int unsigned i = 0; i < MaxLanes; i++) begin
      if (m[i]) hi = i;
    end
    return hi;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// One byte-wide RAM bank: asynchronous read, synchronous write, contents not reset.
module dmem_bank #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AddrW = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [7:0]       wdata_i,
  output logic [7:0]       rdata_o
);

  logic [7:0] mem_q [DEPTH_WORDS];

  // Byte commit on the rising edge.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  // Zero-latency read; a same-cycle write is not yet visible.
  always_comb begin
    rdata_o = mem_q[addr_i];
  end

endmodule

// File: rtl/data_mem.sv
// Data-memory responder for the CPU byte-lane data port.
// Byte-interleaved RAM banks plus an MMIO window with HALT, CYCLE and FAULT_CNT registers.
// Build option: define DMEM_MISALIGN_EN to serve RAM accesses that cross a word boundary;
// without it such accesses fault and are dropped.
module data_mem
  import riscv_mem_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     DEPTH_WORDS = 1024,
  parameter logic [XLEN-1:0] MMIO_BASE   = 'hFFFF_FF00
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN/8-1:0] mem_r,
  input  logic [XLEN/8-1:0] mem_w,
  input  logic [XLEN-1:0]   mem_din,
  output logic [XLEN-1:0]   mem_dout,
  output logic              halt,
  output logic [XLEN-1:0]   halt_code,
  output logic              fault
);

  localparam int unsigned Bytes = XLEN / 8;
  localparam int unsigned OffW  = $clog2(Bytes);
  localparam int unsigned RowW  = $clog2(DEPTH_WORDS);

  localparam logic [Bytes-1:0] AllLanes  = '1;
  localparam logic [XLEN-1:0]  RamLimit  = XLEN'(DEPTH_WORDS * Bytes);
  localparam logic [XLEN-1:0]  MmioSpanB = XLEN'(MMIO_SPAN * Bytes);
  localparam logic [XLEN-1:0]  HaltAddr  = MMIO_BASE + XLEN'(MMIO_HALT_OFS * Bytes);
  localparam logic [XLEN-1:0]  CycleAddr = MMIO_BASE + XLEN'(MMIO_CYCLE_OFS * Bytes);
  localparam logic [XLEN-1:0]  FcntAddr  = MMIO_BASE + XLEN'(MMIO_FCNT_OFS * Bytes);

  // Per-lane decode.
  logic [XLEN-1:0]  lane_addr [Bytes];
  logic [Bytes-1:0] lane_en;
  logic [Bytes-1:0] in_ram;
  logic [Bytes-1:0] in_mmio;
  logic [Bytes-1:0] lane_fault;
  logic [OffW-1:0]  offset;

  // Access-level decode.
  logic mmio_any;
  logic mmio_full;
  logic mmio_fault;
  logic mmio_ok;
  logic mmio_wr;
  logic misalign_fault;
  logic fault_now;
  logic [XLEN-1:0] mmio_rdata;

  // Bank side (indexed by bank, not lane).
  logic            bank_we    [Bytes];
  logic [RowW-1:0] bank_addr  [Bytes];
  logic [7:0]      bank_wdata [Bytes];
  logic [7:0]      bank_rdata [Bytes];
  logic [7:0]      lane_rdata [Bytes];

  // State.
  logic            halt_q, halt_d;
  logic [XLEN-1:0] halt_code_q, halt_code_d;
  logic [XLEN-1:0] cycle_q, cycle_d;
  logic            fault_q, fault_d;
  fault_cnt_t      fault_cnt_q, fault_cnt_d;

  // Lane addresses wrap modulo 2^XLEN; classify each lane into RAM / MMIO / nowhere.
  always_comb begin
    offset = mem_addr[OffW-1:0];
    for (int i = 0; i < Bytes; i++) begin
      lane_addr[i] = mem_addr + XLEN'(i);
      lane_en[i]   = mem_r[i] | mem_w[i];
      in_ram[i]    = lane_addr[i] < RamLimit;
      in_mmio[i]   = (lane_addr[i] - MMIO_BASE) < MmioSpanB;
    end
  end

  // Fault classification: out-of-range lanes, partial/unaligned MMIO, and word-crossing RAM.
  always_comb begin
    mmio_any  = |(lane_en & in_mmio);
    // Every enabled direction must cover the whole aligned word.
    mmio_full = (offset == '0) &&
                ((mem_r == '0) || (mem_r == AllLanes)) &&
                ((mem_w == '0) || (mem_w == AllLanes));
    mmio_fault = mmio_any && !mmio_full;
`ifdef DMEM_MISALIGN_EN
    misalign_fault = 1'b0;
`else
    misalign_fault = (|(lane_en & in_ram)) &&
                     ((32'(offset) + hi_lane(lane_mask_t'(lane_en))) >= Bytes);
`endif
    for (int i = 0; i < Bytes; i++) begin
      // A misaligned access is dropped as a whole; other faults are per lane.
      lane_fault[i] = lane_en[i] & (misalign_fault |
                                    ~(in_ram[i] | in_mmio[i]) |
                                    (in_mmio[i] & mmio_fault));
    end
    fault_now = |lane_fault;
    mmio_ok   = mmio_any && !mmio_fault;
    mmio_wr   = mmio_ok && (mem_w == AllLanes);
  end

  // Rotate lanes onto banks: bank b serves the lane whose address is congruent to b.
  always_comb begin
    for (int b = 0; b < Bytes; b++) begin
      logic [OffW-1:0] l;
      l             = OffW'(b) - offset;
      bank_addr[b]  = lane_addr[l][OffW +: RowW];
      bank_wdata[b] = mem_din[8*l +: 8];
      // Gate with rstn so a write in flight when reset arrives is dropped.
      bank_we[b]    = rstn & mem_w[l] & in_ram[l] & ~lane_fault[l];
    end
    for (int i = 0; i < Bytes; i++) begin
      lane_rdata[i] = bank_rdata[OffW'(i) + offset];
    end
  end

  for (genvar b = 0; b < Bytes; b++) begin : g_bank
    dmem_bank #(
      .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bank (
      .clk_i   (clk),
      .we_i    (bank_we[b]),
      .addr_i  (bank_addr[b]),
      .wdata_i (bank_wdata[b]),
      .rdata_o (bank_rdata[b])
    );
  end

  // MMIO register read mux; unused offsets in the window read zero.
  always_comb begin
    mmio_rdata = '0;
    if (mem_addr == HaltAddr) begin
      mmio_rdata = halt_code_q;
    end else if (mem_addr == CycleAddr) begin
      mmio_rdata = cycle_q;
    end else if (mem_addr == FcntAddr) begin
      mmio_rdata = XLEN'(fault_cnt_q);
    end
  end

  // Read data: disabled or faulting lanes return zero.
  always_comb begin
    mem_dout = '0;
    for (int i = 0; i < Bytes; i++) begin
      if (mem_r[i] && !lane_fault[i]) begin
        if (in_ram[i]) begin
          mem_dout[8*i +: 8] = lane_rdata[i];
        end else if (in_mmio[i]) begin
          mem_dout[8*i +: 8] = mmio_rdata[8*i +: 8];
        end
      end
    end
  end

  // Next-state for HALT, CYCLE, FAULT_CNT and the fault pulse.
  always_comb begin
    halt_d      = halt_q;
    halt_code_d = halt_code_q;
    cycle_d     = cycle_q;
    fault_d     = fault_now;
    fault_cnt_d = fault_cnt_q;
    if (mmio_wr && (mem_addr == HaltAddr)) begin
      halt_d      = 1'b1;
      halt_code_d = mem_din;
    end
    if (!halt_q) cycle_d = cycle_q + 1'b1;
    // A clearing write takes priority over a same-cycle fault.
    if (mmio_wr && (mem_addr == FcntAddr)) begin
      fault_cnt_d = '0;
    end else if (fault_now && (fault_cnt_q != FAULT_CNT_MAX)) begin
      fault_cnt_d = fault_cnt_q + 1'b1;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      halt_q      <= 1'b0;
      halt_code_q <= '0;
      cycle_q     <= '0;
      fault_q     <= 1'b0;
      fault_cnt_q <= '0;
    end else begin
      halt_q      <= halt_d;
      halt_code_q <= halt_code_d;
      cycle_q     <= cycle_d;
      fault_q     <= fault_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  // Output drive.
  always_comb begin
    halt      = halt_q;
    halt_code = halt_code_q;
    fault     = fault_q;
  end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem (XLEN=32, DEPTH_WORDS=1024, MMIO at 0xFFFF_FF00).
module tb_data_mem;

  localparam logic [31:0] HaltA  = 32'hFFFF_FF00;
  localparam logic [31:0] CycleA = 32'hFFFF_FF04;
  localparam logic [31:0] FcntA  = 32'hFFFF_FF08;
  localparam logic [31:0] SpareA = 32'hFFFF_FF0C;
  localparam logic [31:0] OobA   = 32'd4096;

`ifdef DMEM_MISALIGN_EN
  localparam bit MisEn = 1'b1;
`else
  localparam bit MisEn = 1'b0;
`endif
  // Expected RAM words after the misaligned halfword store of 0x1234 at 3.
  localparam logic [31:0] W0Exp   = MisEn ? 32'h34FF_FC18 : 32'hFFFF_FC18;
  localparam logic [31:0] W4Exp   = MisEn ? 32'h0000_0012 : 32'h0000_0018;
  localparam logic [31:0] Fcnt3   = MisEn ? 32'd0 : 32'd1;
  localparam logic        FaultSh = MisEn ? 1'b0 : 1'b1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [3:0]  mem_r = '0;
  logic [3:0]  mem_w = '0;
  logic [31:0] mem_din = '0;
  logic [31:0] mem_dout;
  logic        halt;
  logic [31:0] halt_code;
  logic        fault;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [31:0] exp_q [$];
  string       nm_q [$];
  logic        fexp_q [$];

  data_mem u_dut (
    .clk       (clk),
    .rstn      (rstn),
    .mem_addr  (mem_addr),
    .mem_r     (mem_r),
    .mem_w     (mem_w),
    .mem_din   (mem_din),
    .mem_dout  (mem_dout),
    .halt      (halt),
    .halt_code (halt_code),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  // One access cycle: drive, check read data at negedge, check fault pulse after next posedge.
  task automatic cyc(input logic [31:0] a, input logic [3:0] r, input logic [3:0] w,
                     input logic [31:0] d, input bit chk, input logic [31:0] exp,
                     input logic efault, input string nm);
    logic [31:0] e;
    string       n;
    logic        ef;
    mem_addr = a;
    mem_r    = r;
    mem_w    = w;
    mem_din  = d;
    if (chk) begin
      exp_q.push_back(exp);
      nm_q.push_back(nm);
    end
    fexp_q.push_back(efault);
    @(negedge clk);
    if (chk) begin
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      vectors++;
      if (mem_dout !== e) begin
        $display("FAIL %s: dout got %h expected %h", n, mem_dout, e);
        miscompares++;
      end
    end
    @(posedge clk);
    #1;
    mem_r = '0;
    mem_w = '0;
    ef = fexp_q.pop_front();
    vectors++;
    if (fault !== ef) begin
      $display("FAIL fault_%s: got %b expected %b", nm, fault, ef);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    rstn     = 1'b0;
    mem_addr = HaltA;
    mem_r    = 4'hF;
    @(posedge clk);
    #1;
    vectors++;
    if (halt !== 1'b0) begin
      $display("FAIL reset_halt: got %b expected 0", halt); miscompares++;
    end
    vectors++;
    if (halt_code !== 32'h0) begin
      $display("FAIL reset_halt_code: got %h expected 0", halt_code); miscompares++;
    end
    vectors++;
    if (fault !== 1'b0) begin
      $display("FAIL reset_fault: got %b expected 0", fault); miscompares++;
    end
    vectors++;
    if (mem_dout !== 32'h0) begin
      $display("FAIL reset_halt_rd: got %h expected 0", mem_dout); miscompares++;
    end
    mem_r = '0;
    rstn  = 1'b1;
  endtask

  task automatic test_byte_lanes();
    for (int a = 4; a <= 20; a += 4) cyc(a, 4'h0, 4'hF, 32'h0, 0, 0, 0, "zero");
    cyc(0, 4'h0, 4'hF, 32'hFFFF_FC18, 0, 0, 0, "sw0");
    cyc(0, 4'b0001, 4'h0, 0, 1, 32'h0000_0018, 0, "lb0");
    cyc(0, 4'b0011, 4'h0, 0, 1, 32'h0000_FC18, 0, "lh0");
    cyc(0, 4'hF, 4'h0, 0, 1, 32'hFFFF_FC18, 0, "lw0");
    cyc(4, 4'h0, 4'b0001, 32'h0000_0018, 0, 0, 0, "sb4");
    cyc(12, 4'h0, 4'b0011, 32'h0000_FC18, 0, 0, 0, "sh12");
    cyc(20, 4'h0, 4'hF, 32'hFFFF_FC18, 0, 0, 0, "sw20");
    cyc(4, 4'hF, 4'h0, 0, 1, 32'h0000_0018, 0, "rd4");
    cyc(12, 4'hF, 4'h0, 0, 1, 32'h0000_FC18, 0, "rd12");
    cyc(16, 4'hF, 4'h0, 0, 1, 32'h0, 0, "rd16");
    cyc(20, 4'hF, 4'h0, 0, 1, 32'hFFFF_FC18, 0, "rd20");
  endtask

  task automatic test_rw_same_cycle();
    cyc(8, 4'hF, 4'hF, 32'hAABB_CCDD, 1, 32'h0, 0, "rw_old");
    cyc(8, 4'hF, 4'h0, 0, 1, 32'hAABB_CCDD, 0, "rw_new");
  endtask

  task automatic test_misalign();
    cyc(3, 4'h0, 4'b0011, 32'h0000_1234, 0, 0, FaultSh, "sh3");
    cyc(0, 4'hF, 4'h0, 0, 1, W0Exp, 0, "mis_w0");
    cyc(4, 4'hF, 4'h0, 0, 1, W4Exp, 0, "mis_w4");
    cyc(FcntA, 4'hF, 4'h0, 0, 1, Fcnt3, 0, "mis_fcnt");
  endtask

  task automatic test_range_faults();
    cyc(4092, 4'h0, 4'hF, 32'h5A5A_1234, 0, 0, 0, "sw_last");
    cyc(4092, 4'hF, 4'h0, 0, 1, 32'h5A5A_1234, 0, "lw_last");
    cyc(OobA, 4'hF, 4'h0, 0, 1, 32'h0, 1, "oob_first");
    for (int k = 0; k < 256; k++) cyc(OobA, 4'hF, 4'h0, 0, 1, 32'h0, 1, "oob_rd");
    cyc(FcntA, 4'hF, 4'h0, 0, 1, 32'd255, 0, "fcnt_sat");
    cyc(FcntA, 4'h0, 4'hF, 32'hDEAD_BEEF, 0, 0, 0, "fcnt_clr");
    cyc(FcntA, 4'hF, 4'h0, 0, 1, 32'h0, 0, "fcnt_zero");
    cyc(HaltA, 4'b0001, 4'h0, 0, 1, 32'h0, 1, "mmio_byte");
    cyc(HaltA + 32'd1, 4'hF, 4'h0, 0, 1, 32'h0, 1, "mmio_unal");
    cyc(SpareA, 4'hF, 4'hF, 32'h1111_1111, 1, 32'h0, 0, "mmio_spare");
    cyc(FcntA, 4'hF, 4'h0, 0, 1, 32'd2, 0, "fcnt_two");
  endtask

  task automatic test_halt_cycle();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    for (int k = 0; k < 9; k++) cyc(0, 4'h0, 4'h0, 0, 0, 0, 0, "idle");
    cyc(HaltA, 4'h0, 4'hF, 32'd7, 0, 0, 0, "halt7");
    vectors++;
    if (halt !== 1'b1) begin
      $display("FAIL halt_set: got %b expected 1", halt); miscompares++;
    end
    vectors++;
    if (halt_code !== 32'd7) begin
      $display("FAIL halt_code7: got %h expected 7", halt_code); miscompares++;
    end
    cyc(CycleA, 4'hF, 4'h0, 0, 1, 32'd10, 0, "cycle10");
    for (int k = 0; k < 3; k++) cyc(0, 4'h0, 4'h0, 0, 0, 0, 0, "idle");
    cyc(CycleA, 4'hF, 4'h0, 0, 1, 32'd10, 0, "cycle_frozen");
    cyc(HaltA, 4'hF, 4'h0, 0, 1, 32'd7, 0, "halt_rd");
    cyc(HaltA, 4'h0, 4'hF, 32'd9, 0, 0, 0, "halt9");
    vectors++;
    if (halt_code !== 32'd9) begin
      $display("FAIL halt_code9: got %h expected 9", halt_code); miscompares++;
    end
    vectors++;
    if (halt !== 1'b1) begin
      $display("FAIL halt_sticky: got %b expected 1", halt); miscompares++;
    end
    cyc(CycleA, 4'h0, 4'hF, 32'h0, 0, 0, 0, "cycle_wr");
    cyc(CycleA, 4'hF, 4'h0, 0, 1, 32'd10, 0, "cycle_ro");
  endtask

  task automatic test_reset_mid_run();
    cyc(OobA, 4'hF, 4'h0, 0, 1, 32'h0, 1, "pre_rst_fault");
    rstn = 1'b0;
    #1;
    vectors++;
    if (halt !== 1'b0) begin
      $display("FAIL mid_rst_halt: got %b expected 0", halt); miscompares++;
    end
    vectors++;
    if (halt_code !== 32'h0) begin
      $display("FAIL mid_rst_code: got %h expected 0", halt_code); miscompares++;
    end
    vectors++;
    if (fault !== 1'b0) begin
      $display("FAIL mid_rst_fault: got %b expected 0", fault); miscompares++;
    end
    rstn = 1'b1;
    cyc(CycleA, 4'hF, 4'h0, 0, 1, 32'h0, 0, "rst_cycle");
    cyc(FcntA, 4'hF, 4'h0, 0, 1, 32'h0, 0, "rst_fcnt");
    cyc(0, 4'hF, 4'h0, 0, 1, W0Exp, 0, "rst_ram_kept");
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_rw_same_cycle();
    test_misalign();
    test_range_faults();
    test_halt_cycle();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
